// File: rtl/vend_pkg.sv
// Shared types and default parameters for the coin-credit vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } vend_state_e;

  localparam int DEFAULT_NUM_COINS = 3;
  localparam int DEFAULT_CREDIT_W  = 8;
  // Index 0 is the smallest denomination; values must ascend with index.
  localparam logic [2:0][7:0] DEFAULT_COIN_VAL = {8'd25, 8'd10, 8'd5};
  localparam int DEFAULT_MAX_CREDIT = 100;

endpackage

// File: rtl/coin_edge_detect.sv
// Rising-edge detector for the coin sensors with lowest-index priority;
// extra simultaneous edges are flagged so the caller can reject them.
module coin_edge_detect #(
  parameter int NUM_COINS = 3,
  localparam int IDX_W = $clog2(NUM_COINS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_COINS-1:0] coin,
  output logic                 coin_hit,
  output logic [IDX_W-1:0]     coin_idx,
  output logic                 coin_multi_reject
);

  logic [NUM_COINS-1:0] coin_q;
  logic [NUM_COINS-1:0] coin_edge;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coin_q <= '0;
    end else begin
      coin_q <= coin;
    end
  end

  assign coin_edge = coin & ~coin_q;

  always_comb begin
    coin_idx = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (coin_edge[i]) coin_idx = IDX_W'(i);
    end
  end

  assign coin_hit = |coin_edge;
  // Clearing the lowest set bit leaves something only when two or more edges coincide.
  assign coin_multi_reject = |(coin_edge & (coin_edge - NUM_COINS'(1)));

endmodule

// File: rtl/vend_credit_ctrl.sv
// Coin-credit controller: accumulates coin credit with saturation, vends when
// credit covers the price, and returns change one coin per handshake.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_COINS = DEFAULT_NUM_COINS,
  parameter int CREDIT_W  = DEFAULT_CREDIT_W,
  parameter logic [NUM_COINS-1:0][CREDIT_W-1:0] COIN_VAL = DEFAULT_COIN_VAL,
  parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT,
  localparam int IDX_W = $clog2(NUM_COINS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_COINS-1:0] coin_i,
  input  logic                 cancel_i,
  input  logic [CREDIT_W-1:0]  price_i,
  input  logic                 change_ready_i,
  output logic [CREDIT_W-1:0]  credit_o,
  output logic                 vend_o,
  output logic                 coin_reject_o,
  output logic                 change_valid_o,
  output logic [IDX_W-1:0]     change_coin_o,
  output logic                 busy_o,
  output logic [1:0]           state_o
);

  // Change handshake: a coin transfers on any cycle where change_valid_o and
  // change_ready_i are both high; until then valid and change_coin_o hold steady.

  localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W + 1)'(MAX_CREDIT);

  vend_state_e         state;
  logic                coin_hit;
  logic                coin_multi_reject;
  logic [IDX_W-1:0]    coin_idx;
  logic [CREDIT_W-1:0] price_q;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_sat;
  logic [CREDIT_W-1:0] credit_acc;
  logic [CREDIT_W-1:0] credit_paid;
  logic [CREDIT_W-1:0] credit_chg;
  logic [IDX_W:0]      pick_paid;
  logic [IDX_W:0]      pick_acc;
  logic [IDX_W:0]      pick_chg;

  coin_edge_detect #(
    .NUM_COINS(NUM_COINS)
  ) u_edge (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .coin             (coin_i),
    .coin_hit         (coin_hit),
    .coin_idx         (coin_idx),
    .coin_multi_reject(coin_multi_reject)
  );

  // Returns {found, index} of the largest coin not exceeding amount.
  function automatic logic [IDX_W:0] pick_change(input logic [CREDIT_W-1:0] amount);
    logic [IDX_W:0] pick;
    pick = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (COIN_VAL[i] <= amount) pick = {1'b1, IDX_W'(i)};
    end
    return pick;
  endfunction

  assign coin_val    = COIN_VAL[coin_idx];
  assign coin_sum    = {1'b0, credit_o} + {1'b0, coin_val};
  assign coin_sat    = coin_sum > MAX_EXT;
  assign credit_acc  = (coin_hit && !coin_sat) ? coin_sum[CREDIT_W-1:0] : credit_o;
  assign credit_paid = credit_o - price_q;
  assign credit_chg  = credit_o - COIN_VAL[change_coin_o];
  assign pick_paid   = pick_change(credit_paid);
  assign pick_acc    = pick_change(credit_acc);
  assign pick_chg    = pick_change(credit_chg);
  assign state_o     = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      credit_o       <= '0;
      price_q        <= '0;
      vend_o         <= 1'b0;
      coin_reject_o  <= 1'b0;
      change_valid_o <= 1'b0;
      change_coin_o  <= '0;
      busy_o         <= 1'b0;
    end else begin
      vend_o <= 1'b0;
      unique case (state)
        IDLE: begin
          coin_reject_o <= coin_multi_reject | (coin_hit & coin_sat);
          credit_o      <= credit_acc;
          if (coin_hit && !coin_sat) state <= ACCUM;
        end
        ACCUM: begin
          coin_reject_o <= coin_multi_reject | (coin_hit & coin_sat);
          credit_o      <= credit_acc;
          // Decisions use the registered credit; a coin landing now still counts.
          if (cancel_i) begin
            state          <= CHANGE;
            busy_o         <= 1'b1;
            change_valid_o <= pick_acc[IDX_W];
            change_coin_o  <= pick_acc[IDX_W-1:0];
          end else if (credit_o >= price_i && price_i != '0) begin
            state   <= VEND;
            busy_o  <= 1'b1;
            vend_o  <= 1'b1;
            price_q <= price_i;
          end
        end
        VEND: begin
          coin_reject_o <= coin_hit;
          credit_o      <= credit_paid;
          if (credit_paid != '0) begin
            state          <= CHANGE;
            change_valid_o <= pick_paid[IDX_W];
            change_coin_o  <= pick_paid[IDX_W-1:0];
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        CHANGE: begin
          coin_reject_o <= coin_hit;
          if (!change_valid_o) begin
            // Residue smaller than any coin cannot be returned and is dropped.
            state         <= IDLE;
            busy_o        <= 1'b0;
            credit_o      <= '0;
            change_coin_o <= '0;
          end else if (change_ready_i) begin
            credit_o <= credit_chg;
            if (credit_chg == '0) begin
              state          <= IDLE;
              busy_o         <= 1'b0;
              change_valid_o <= 1'b0;
              change_coin_o  <= '0;
            end else begin
              change_valid_o <= pick_chg[IDX_W];
              change_coin_o  <= pick_chg[IDX_W-1:0];
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Parametrised coin-credit controller for the vending datapath. It accepts pulses from N coin sensor channels with configurable denominations and keeps a running credit. When credit reaches the price it issues a vend pulse, then returns change one coin at a time over a valid/ready handshake. It replaces the fixed three-coin selector: the adder-mux decision now sits inside a credit accumulator with saturation, cancel and change return.

## Interface
- NUM_COINS, 3, number of coin channels; channel 0 is the smallest denomination.
- CREDIT_W, 8, width of credit, price and coin values.
- COIN_VAL, {25,10,5} (index 2..0), packed array [NUM_COINS-1:0][CREDIT_W-1:0] of coin values. Must be strictly ascending with index.
- MAX_CREDIT, 100, credit ceiling. Must be ≤ 2^CREDIT_W−1.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- coin_i  in  NUM_COINS  level-high coin sensor per channel; one coin per rising edge.
- cancel_i  in  1  return all credit as change.
- price_i  in  CREDIT_W  item price; sampled every cycle in ACCUM.
- change_ready_i  in  1  change dispenser accepts coin.
- credit_o  out  CREDIT_W  current credit.
- vend_o  out  1  one-cycle vend pulse.
- coin_reject_o  out  1  one-cycle pulse; a detected coin edge was not credited.
- change_valid_o  out  1  change coin offered.
- change_coin_o  out  $clog2(NUM_COINS)  channel index of the offered coin.
- busy_o  out  1  high in VEND or CHANGE.

## Operation
- Edge detect: coin_q registers coin_i. edge = coin_i & ~coin_q. If several edges occur in one cycle, the lowest index is credited and the rest raise coin_reject_o in the same cycle.
- States: IDLE, ACCUM, VEND, CHANGE.
- IDLE: credit is 0. An accepted edge adds its COIN_VAL and moves to ACCUM. cancel_i is ignored.
- ACCUM: an accepted edge adds its value. If credit + value > MAX_CREDIT, the coin is rejected and credit is unchanged. The state then reacts to the registered credit:
  - If cancel_i is asserted: go to CHANGE. cancel_i has priority over vend.
  - Else if credit ≥ price_i and price_i ≠ 0: go to VEND.
- VEND: vend_o = 1 for exactly one cycle and credit −= price_i, using the price value latched on entry. If the result is > 0, go to CHANGE, else go to IDLE.
- CHANGE: change_valid_o = 1 and change_coin_o = the highest index with COIN_VAL ≤ credit. On valid & ready, credit −= that value. When credit reaches 0, go to IDLE.
  - If credit is nonzero but below COIN_VAL[0], clear credit and go to IDLE with no handshake. The residue is forfeited.
- All coin edges seen in VEND or CHANGE raise coin_reject_o and are not credited.
- All arithmetic is unsigned, CREDIT_W bits. The saturation check uses a CREDIT_W+1-bit sum.

## Timing
- Reset values: state IDLE, coin_q 0, credit_o 0, vend_o 0, coin_reject_o 0, change_valid_o 0, change_coin_o 0, busy_o 0.
- Coin latency:
  - A rising edge in cycle k updates credit_o in cycle k+1.
  - coin_reject_o is a registered pulse in cycle k+1.
- Vend latency: credit ≥ price visible in cycle k → VEND in k+1 (vend_o high) → CHANGE or IDLE in k+2, with credit_o already reduced.
- change_valid_o holds, with change_coin_o stable, until ready is seen. The credit decrement and the next coin choice appear in the following cycle. With ready held high, one coin transfers per cycle.
- Reset asserted mid-operation (including during CHANGE) clears credit immediately. Any dispensing in progress is abandoned.

## Structure
- Shared package vend_pkg holds:
  - the vend_state_e enum {IDLE, ACCUM, VEND, CHANGE};
  - the default COIN_VAL constant;
  - the MAX_CREDIT default.
- Sub-module coin_edge_detect, parametrised by NUM_COINS, contains:
  - the coin_q register;
  - rising-edge detection and the lowest-index priority encoder;
  - outputs: coin_hit, coin_idx, coin_multi_reject.
- The top level contains the FSM, the credit register, saturation logic and the change coin selector.

## Test plan
- Insert 5 then 10 with price 15: credit goes 5 → 15; vend_o pulses one cycle; credit returns to 0; state returns to IDLE; no change handshake.
- Insert 25 with price 15: vend_o pulses; change offers channel 1 (10) with ready=1; credit is 0 the next cycle.
- Insert 10, 5 with price 40, then cancel_i: change offers 10, then 5. Hold ready low for 3 cycles: valid and coin stay stable until ready.
- Rising edges on channels 0 and 2 in the same cycle: credit +5 and coin_reject_o pulses once.
- Credit at 90 with MAX_CREDIT 100: inserting a 25 raises coin_reject_o and credit stays 90. Inserting during CHANGE is also rejected.
- Assert rst_ni low during CHANGE with credit 20: all outputs return to their reset values while reset is held. Insert 5 after release: credit is 5.
